serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
- Bit-serial adder sequencer for the 1-bit full adder cell.
- Loads two WIDTH-bit operands and presents one bit pair per clock, LSB first, to the full adder's a/b/cin inputs.
- Consumes the full adder's s/cout, accumulates s into a sum shift register and holds cout in a carry flip-flop for the next bit.
- Top level wires fa_a/fa_b/fa_cin to the full adder inputs and its s/cout back to fa_s/fa_cout.

Parameters:
WIDTH  8  operand and sum width in bits (must be ≥ 2)

Ports:
clk      input   1      system clock; all state changes on rising edge
rst_n    input   1      asynchronous, active-low reset
start    input   1      request a new addition; sampled on rising clk
a        input   WIDTH  operand A; captured on accepted start
b        input   WIDTH  operand B; captured on accepted start
cin      input   1      initial carry; captured on accepted start
fa_a     output  1      bit to full adder input a (A shift reg bit 0)
fa_b     output  1      bit to full adder input b (B shift reg bit 0)
fa_cin   output  1      carry to full adder input cin (carry flip-flop)
fa_s     input   1      sum bit returned by the full adder
fa_cout  input   1      carry-out returned by the full adder
busy     output  1      high while bits are being processed
done     output  1      one-cycle pulse when sum/cout become valid
sum      output  WIDTH  result; held stable from done until next accepted start
cout     output  1      final carry-out; held with sum

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, A/B shift regs=0, carry=0, bit counter=0, sum=0, cout=0, busy=0, done=0. Any operation in progress is aborted with no done pulse. Outputs leave reset only on the first rising clk after rst_n rises.
- State machine has three states: IDLE, RUN, DONE.
- IDLE or DONE with start=1:
  - Capture a, b, cin into the A reg, B reg and carry flip-flop.
  - Clear the counter; next state=RUN.
  - busy=1 from the next cycle.
  - Start is also accepted in the DONE cycle, so back-to-back operation is allowed.
- IDLE with start=0: remain in IDLE; all regs hold.
- RUN, each cycle:
  - fa_a=A[0], fa_b=B[0], fa_cin=carry (combinational from registers).
  - At the clock edge: sum <= {fa_s, sum[WIDTH-1:1]}; carry <= fa_cout; A and B shift right with 0 fill; counter += 1.
  - When the counter reaches WIDTH-1 at the edge, next state=DONE and cout <= fa_cout.
- RUN ignores start.
- DONE: busy=0, done=1 for exactly one cycle; next state=IDLE unless start is accepted.
- The sum register is an intermediate value during RUN; sum and cout are guaranteed valid only from the done cycle onward.
- Latency: start is sampled at edge k. busy is high for cycles k+1 .. k+WIDTH. done is high in cycle k+WIDTH+1.
- Outputs fa_a/fa_b/fa_cin are always driven from the registers. Their values outside RUN are don't-care for the full adder, but must be 0 after reset.
- Counter width is clog2(WIDTH). It must not wrap within an operation.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1). Operands are unsigned.

Test Plan:
- Bench instantiates the 1-bit full adder and connects it as described in the Overview; WIDTH=8.
- a=8'h3C, b=8'h5A, cin=0, start for 1 cycle → busy high for 8 cycles, done pulse in cycle 9, sum=8'h96, cout=0.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1 (full carry ripple). Then a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
- Start with a=8'h01, b=8'h01; raise start again with new operands 3 cycles into RUN → ignored; result is sum=8'h02, cout=0, single done pulse.
- Assert start in the done cycle with a=8'h10, b=8'h20 → previous result seen at done; the new operation completes 9 cycles later with sum=8'h30; no idle cycle between the two.
- Pull rst_n low asynchronously mid-RUN (between clock edges) → busy, done, sum, cout go to 0 immediately; no done pulse follows. A new start after release produces a correct result.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: feeds an external 1-bit full adder one bit pair per
// clock (LSB first) and assembles its sum bits and final carry into a WIDTH-bit result.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
    logic             w_last;

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_sum   <= {fa_s, r_sum[WIDTH-1:1]};
                    r_carry <= fa_cout;
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    // Counter is cleared rather than incremented on the last bit so it never wraps.
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_cout  <= fa_cout;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign fa_a   = r_a[0];
    assign fa_b   = r_b[0];
    assign fa_cin = r_carry;
    assign busy   = r_busy;
    assign done   = r_done;
    assign sum    = r_sum;
    assign cout   = r_cout;

endmodule
